a2d_arbiter: RTL and testbench
==============================

Name: a2d_arbiter

Overview:
Shares the single A2D converter interface (start_conv/chnnl/cnv_cmplt/A2D_res) between two requesters. Port 0 is the motion controller's IR sensor sequencer; port 1 is an auxiliary requester such as a battery or steering monitor. The block does round-robin arbitration, holds the channel select while the A2D mux settles, issues start_conv, and waits for cnv_cmplt with a timeout. It then returns the 12-bit result to the granted requester with a one-cycle done pulse.

Parameters:
SETTLE_CYC, 8, cycles between a channel change and the start_conv pulse; legal range 1..255.
TIMEOUT_CYC, 1024, maximum cycles to wait for cnv_cmplt after start_conv; legal range 2..65535.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
req0  input  1  requester 0 conversion request (level; held until done0)
chnl0  input  3  requester 0 A2D channel
req1  input  1  requester 1 conversion request (level; held until done1)
chnl1  input  3  requester 1 A2D channel
cnv_cmplt  input  1  A2D conversion complete strobe
A2D_res  input  12  A2D result, valid while cnv_cmplt is high
start_conv  output  1  one-cycle pulse to start a conversion
chnnl  output  3  channel select to the A2D
gnt0, gnt1  output  1 each  high from grant until the done cycle, inclusive
done0, done1  output  1 each  one-cycle completion pulse
res0, res1  output  12 each  last result per requester; held between conversions
err  output  1  one-cycle pulse coincident with done on a timeout
busy  output  1  high in any state other than IDLE

Behaviour:
- Clocking and outputs:
  - All outputs are registered.
  - Reset is sampled only at the rising edge of clk. When rst_n is low: state=IDLE, start_conv=0, chnnl=0, gnt*=0, done*=0, err=0, res*=0, counter=0, last_grant=1 (so requester 0 wins the first tie).
  - Reset asserted mid-transaction aborts the transaction immediately. No done pulse is produced and no res is updated.
- States: IDLE, SETTLE, WAIT, DONE.
- IDLE:
  - If no request is pending, remain in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the requester that is not last_grant.
  - On a grant at edge k: chnnl<=chnlN, gntN<=1, last_grant<=N, cnt<=0, state->SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYC-1: start_conv<=1 for exactly one cycle, cnt<=0, state->WAIT.
  - start_conv is therefore high in the cycle after edge k+SETTLE_CYC.
- WAIT:
  - If cnv_cmplt is high: resN<=A2D_res, doneN<=1, state->DONE.
  - Otherwise, if cnt==TIMEOUT_CYC-1: doneN<=1, err<=1, resN is unchanged, state->DONE.
  - Otherwise cnt increments.
  - If cnv_cmplt is high in the same cycle the timeout is reached, completion wins: result captured, err=0.
- DONE:
  - One cycle. doneN and err are high during it; gntN clears at the end of the cycle; state->IDLE.
  - Requests are not sampled in DONE. This gives a requester that deasserts reqN on seeing doneN one cycle to drop its request before the next arbitration.
- Stability and ignored inputs:
  - chnnl is held constant from grant through DONE and keeps its last value in IDLE.
  - chnl0 and chnl1 are sampled only at grant.
  - cnv_cmplt is ignored outside WAIT.
- A requester that drops reqN mid-transaction does not abort it. The conversion completes and doneN still pulses.
- A requester that keeps reqN high after doneN is treated as a new request in the following IDLE cycle, subject to round-robin.
- Back-to-back throughput: each transaction takes SETTLE_CYC + conversion time + 2 cycles (WAIT exit + DONE) + 1 IDLE cycle.
- Exactly one of gnt0 and gnt1 may be high at any time; never both.

Test Plan:
- Reset then single request: req0=1, chnl0=3'd4, SETTLE_CYC=8. Expect gnt0 and chnnl=4 one cycle later, start_conv pulse 8 cycles after the grant edge. Drive cnv_cmplt with A2D_res=12'hA5C 20 cycles later. Expect res0=12'hA5C, done0 pulse, err=0, res1 still 0.
- Simultaneous requests: req0=req1=1 from reset, chnl0=1, chnl1=7, both held high. Expect grant order 0,1,0,1, with chnnl alternating 1,7,1,7.
- Timeout: TIMEOUT_CYC=16, req1=1, cnv_cmplt never asserted. Expect done1 and err high together exactly 16 cycles after start_conv, res1 unchanged, next transaction served normally.
- Completion on the timeout boundary: assert cnv_cmplt with A2D_res=12'h123 in the final WAIT cycle. Expect res=12'h123 and err=0.
- Mid-operation events:
  - Drop req0 during SETTLE: conversion still issued, done0 still pulses.
  - Toggle chnl0 during WAIT: chnnl stays constant.
  - Pulse cnv_cmplt while in IDLE: ignored.
- Reset mid-WAIT: pull rst_n low for 1 cycle. Expect state IDLE, all outputs 0, no done pulse, res unchanged from its reset value 0; the next req0 is granted first.

Source files
------------

// File: rtl/a2d_arbiter_if.sv
// ============================================================================
//  Module   : a2d_arbiter_if
//  Function : Requester + A2D handshake bundle for the two-port A2D arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface a2d_arbiter_if;
    logic        req0;
    logic [2:0]  chnl0;
    logic        req1;
    logic [2:0]  chnl1;
    logic        cnv_cmplt;
    logic [11:0] A2D_res;
    logic        start_conv;
    logic [2:0]  chnnl;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [11:0] res0;
    logic [11:0] res1;
    logic        err;
    logic        busy;

    // Arbiter side
    modport slave (
        input  req0, chnl0, req1, chnl1, cnv_cmplt, A2D_res,
        output start_conv, chnnl, gnt0, gnt1, done0, done1, res0, res1, err, busy
    );

    // Requesters plus A2D converter side
    modport master (
        output req0, chnl0, req1, chnl1, cnv_cmplt, A2D_res,
        input  start_conv, chnnl, gnt0, gnt1, done0, done1, res0, res1, err, busy
    );
endinterface

`default_nettype wire

// File: rtl/a2d_arbiter.sv
// ============================================================================
//  Module   : a2d_arbiter
//  Function : Round-robin sharing of one A2D converter between two requesters,
//             with mux settle delay, conversion timeout and per-port results.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module a2d_arbiter #(
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  wire             clk,
    input  wire             rst_n,
    a2d_arbiter_if.slave    bus
);

    localparam logic [1:0] C_IDLE   = 2'd0;
    localparam logic [1:0] C_SETTLE = 2'd1;
    localparam logic [1:0] C_WAIT   = 2'd2;
    localparam logic [1:0] C_DONE   = 2'd3;

    localparam logic [15:0] C_SETTLE_LAST  = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    logic [1:0]  state_q,      state_d;
    logic [15:0] cnt_q,        cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        start_conv_q, start_conv_d;
    logic [2:0]  chnnl_q,      chnnl_d;
    logic        gnt0_q,       gnt0_d;
    logic        gnt1_q,       gnt1_d;
    logic        done0_q,      done0_d;
    logic        done1_q,      done1_d;
    logic [11:0] res0_q,       res0_d;
    logic [11:0] res1_q,       res1_d;
    logic        err_q,        err_d;
    logic        busy_q,       busy_d;

    logic        w_any_req;
    logic        w_pick1;
    logic        w_settle_end;
    logic        w_timeout;

    assign w_any_req    = bus.req0 | bus.req1;
    // Requester 1 wins when alone, or on a tie when requester 0 was served last
    assign w_pick1      = bus.req1 & (~bus.req0 | ~last_grant_q);
    assign w_settle_end = (cnt_q == C_SETTLE_LAST);
    assign w_timeout    = (cnt_q == C_TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= C_IDLE;
            cnt_q        <= 16'd0;
            last_grant_q <= 1'b1;
            start_conv_q <= 1'b0;
            chnnl_q      <= 3'd0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            res0_q       <= 12'd0;
            res1_q       <= 12'd0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            start_conv_q <= start_conv_d;
            chnnl_q      <= chnnl_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            res0_q       <= res0_d;
            res1_q       <= res1_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE:   if (w_any_req)                  state_d = C_SETTLE;
            C_SETTLE: if (w_settle_end)               state_d = C_WAIT;
            C_WAIT:   if (bus.cnv_cmplt || w_timeout) state_d = C_DONE;
            C_DONE:                                   state_d = C_IDLE;
            default:                                  state_d = C_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        start_conv_d = 1'b0;
        chnnl_d      = chnnl_q;
        gnt0_d       = gnt0_q;
        gnt1_d       = gnt1_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        res0_d       = res0_q;
        res1_d       = res1_q;
        err_d        = 1'b0;
        busy_d       = (state_d != C_IDLE);

        case (state_q)
            C_IDLE: begin
                if (w_any_req) begin
                    chnnl_d      = w_pick1 ? bus.chnl1 : bus.chnl0;
                    gnt0_d       = ~w_pick1;
                    gnt1_d       = w_pick1;
                    last_grant_d = w_pick1;
                    cnt_d        = 16'd0;
                end
            end
            C_SETTLE: begin
                if (w_settle_end) begin
                    start_conv_d = 1'b1;
                    cnt_d        = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            C_WAIT: begin
                // Completion takes priority over a coincident timeout
                if (bus.cnv_cmplt) begin
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                    if (gnt1_q) res1_d = bus.A2D_res;
                    else        res0_d = bus.A2D_res;
                end else if (w_timeout) begin
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            C_DONE: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.start_conv = start_conv_q;
    assign bus.chnnl      = chnnl_q;
    assign bus.gnt0       = gnt0_q;
    assign bus.gnt1       = gnt1_q;
    assign bus.done0      = done0_q;
    assign bus.done1      = done1_q;
    assign bus.res0       = res0_q;
    assign bus.res1       = res1_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_a2d_arbiter.sv
// ============================================================================
//  Module   : tb_a2d_arbiter
//  Function : Directed, table-driven self-checking bench for a2d_arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_a2d_arbiter;

    localparam int SETTLE_CYC  = 8;
    localparam int TIMEOUT_CYC = 16;

    logic clk;
    logic rst_n;
    a2d_arbiter_if bus ();

    a2d_arbiter #(
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          pre_rst;  // reset before this transaction
        bit          r0;
        bit          r1;
        bit          keep;     // keep requests high after done
        bit          drop;     // drop granted request during settle
        logic [2:0]  c0;
        logic [2:0]  c1;
        int          delay;    // WAIT cycle in which cnv_cmplt fires, -1 = never
        logic [11:0] val;
        int          port;     // expected granted port
        logic [2:0]  ch;       // expected chnnl
    } vec_t;

    int n_checks;
    int n_err;
    logic [11:0] m_res0;
    logic [11:0] m_res1;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int  n;
        int  j;
        int  exp_lat;
        bit  exp_to;
        bit  extra_start;
        bit  both_gnt;
        logic [1:0] exp_oh;

        exp_oh = (v.port == 1) ? 2'b10 : 2'b01;
        if (v.pre_rst) begin
            rst_n    = 1'b0;
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            @(negedge clk);
            rst_n  = 1'b1;
            m_res0 = 12'd0;
            m_res1 = 12'd0;
        end
        bus.chnl0 = v.c0;
        bus.chnl1 = v.c1;
        bus.req0  = v.r0;
        bus.req1  = v.r1;

        n = 0;
        while (!(bus.gnt0 || bus.gnt1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("grant_seen", 64'(bus.gnt0 | bus.gnt1), 64'd1);
        chk("grant_port", 64'({bus.gnt1, bus.gnt0}), 64'(exp_oh));
        chk("grant_chnnl", 64'(bus.chnnl), 64'(v.ch));

        both_gnt = 1'b0;
        n = 0;
        while (!bus.start_conv && n < SETTLE_CYC + 4) begin
            if (v.drop && n == 2) begin
                if (v.port == 1) bus.req1 = 1'b0;
                else             bus.req0 = 1'b0;
            end
            @(negedge clk);
            if (bus.gnt0 && bus.gnt1) both_gnt = 1'b1;
            n++;
        end
        chk("settle_len", 64'(n), 64'(SETTLE_CYC));

        exp_to  = (v.delay < 0) || (v.delay >= TIMEOUT_CYC);
        exp_lat = exp_to ? TIMEOUT_CYC : v.delay + 1;
        extra_start = 1'b0;
        bus.chnl0 = ~v.c0;
        bus.chnl1 = ~v.c1;
        j = 0;
        while (j < TIMEOUT_CYC + 4) begin
            if (j == v.delay) begin
                bus.cnv_cmplt = 1'b1;
                bus.A2D_res   = v.val;
            end
            @(negedge clk);
            bus.cnv_cmplt = 1'b0;
            bus.A2D_res   = 12'($urandom);
            if (bus.start_conv) extra_start = 1'b1;
            if (bus.gnt0 && bus.gnt1) both_gnt = 1'b1;
            if (bus.done0 || bus.done1) break;
            j++;
        end
        chk("done_latency", 64'(j + 1), 64'(exp_lat));
        chk("start_single_pulse", 64'(extra_start), 64'd0);
        chk("never_both_gnt", 64'(both_gnt), 64'd0);
        chk("done_port", 64'({bus.done1, bus.done0}), 64'(exp_oh));
        chk("err", 64'(bus.err), 64'(exp_to));
        if (!exp_to) begin
            if (v.port == 1) m_res1 = v.val;
            else             m_res0 = v.val;
        end
        chk("res0", 64'(bus.res0), 64'(m_res0));
        chk("res1", 64'(bus.res1), 64'(m_res1));
        chk("held_gnt_chnnl", 64'({bus.gnt1, bus.gnt0, bus.chnnl, bus.busy}),
            64'({exp_oh, v.ch, 1'b1}));

        bus.chnl0 = v.c0;
        bus.chnl1 = v.c1;
        if (!v.keep) begin
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
        end
        @(negedge clk);
        chk("idle_after_done", 64'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.busy}), 64'd0);
    endtask

    initial begin
        vec_t rv;
        int   n;

        n_checks = 0;
        n_err    = 0;
        m_res0   = 12'd0;
        m_res1   = 12'd0;

        //            rst  r0 r1 keep drop c0    c1    delay            val      port ch
        vecs[0] = '{1'b0, 1, 0, 0,   0,  3'd4, 3'd0, 20,              12'hA5C, 0,   3'd4};
        vecs[1] = '{1'b0, 0, 1, 0,   0,  3'd0, 3'd5, -1,              12'hBAD, 1,   3'd5};
        vecs[2] = '{1'b0, 0, 1, 0,   0,  3'd0, 3'd6, TIMEOUT_CYC - 1, 12'h123, 1,   3'd6};
        vecs[3] = '{1'b0, 1, 0, 0,   1,  3'd2, 3'd0, 3,               12'h7E1, 0,   3'd2};
        vecs[4] = '{1'b1, 1, 1, 1,   0,  3'd1, 3'd7, 2,               12'h111, 0,   3'd1};
        vecs[5] = '{1'b0, 1, 1, 1,   0,  3'd1, 3'd7, 5,               12'h222, 1,   3'd7};
        vecs[6] = '{1'b0, 1, 1, 1,   0,  3'd1, 3'd7, 0,               12'h333, 0,   3'd1};
        vecs[7] = '{1'b0, 1, 1, 0,   0,  3'd1, 3'd7, 1,               12'h444, 1,   3'd7};

        rst_n         = 1'b0;
        bus.req0      = 1'b0;
        bus.req1      = 1'b0;
        bus.chnl0     = 3'd0;
        bus.chnl1     = 3'd0;
        bus.cnv_cmplt = 1'b0;
        bus.A2D_res   = 12'd0;
        repeat (3) @(negedge clk);
        chk("reset_state", 64'({bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err,
                                bus.start_conv, bus.chnnl, bus.res0, bus.res1}), 64'd0);
        rst_n = 1'b1;

        // A stray completion strobe while idle must not produce anything
        @(negedge clk);
        bus.cnv_cmplt = 1'b1;
        bus.A2D_res   = 12'hFFF;
        @(negedge clk);
        bus.cnv_cmplt = 1'b0;
        @(negedge clk);
        chk("idle_cmplt_ignored", 64'({bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1,
                                       bus.err, bus.res0, bus.res1}), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
        end

        // Reset in the middle of WAIT aborts the transaction silently
        bus.chnl0 = 3'd3;
        bus.req0  = 1'b1;
        n = 0;
        while (!bus.start_conv && n < SETTLE_CYC + 10) begin
            @(negedge clk);
            n++;
        end
        chk("rstwait_reached_start", 64'(bus.start_conv), 64'd1);
        repeat (3) @(negedge clk);
        rst_n    = 1'b0;
        bus.req1 = 1'b1;
        bus.chnl1 = 3'd6;
        @(negedge clk);
        chk("rstwait_outputs_clear", 64'({bus.busy, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err,
                                          bus.start_conv, bus.chnnl, bus.res0, bus.res1}), 64'd0);
        rst_n  = 1'b1;
        m_res0 = 12'd0;
        m_res1 = 12'd0;
        rv = '{1'b0, 1, 1, 0, 0, 3'd3, 3'd6, 4, 12'h9C3, 0, 3'd3};
        run_txn(rv);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
